// File: rtl/gdo.sv
// Element arithmetic shared by the compute blocks: wrap-around unsigned integer ops.
// Callers size-cast the 64-bit result down to their element width.
package gdo;

  function automatic logic [63:0] gdo_mult(input logic [63:0] a, input logic [63:0] b);
    return a * b;
  endfunction

  function automatic logic [63:0] gdo_add(input logic [63:0] a, input logic [63:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/systolic_pkg.sv
// Shared types and packing helpers for the streaming systolic tile.
package systolic_pkg;

  typedef enum logic [1:0] {StIdle, StAccum, StFlush, StDrain} state_e;

  // MSB index of a lane in an MSB-first packed bus (lane 0 in the top bits).
  function automatic int unsigned lane_hi(input int unsigned lane, input int unsigned lanes,
                                          input int unsigned width);
    return width * (lanes - lane) - 1;
  endfunction

  function automatic int unsigned flush_cnt_w(input int unsigned rows, input int unsigned cols);
    return $clog2(rows + cols);
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// Output-stationary MAC cell: forwards a east and b south one cycle later.
module systolic_pe #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [DATA_W-1:0] a_west,
  input  logic              va_west,
  input  logic [DATA_W-1:0] b_north,
  input  logic              vb_north,
  output logic [DATA_W-1:0] a_east,
  output logic              va_east,
  output logic [DATA_W-1:0] b_south,
  output logic              vb_south,
  output logic [DATA_W-1:0] acc
);

  always_ff @(posedge clk) begin
    if (reset) begin
      a_east   <= '0;
      va_east  <= 1'b0;
      b_south  <= '0;
      vb_south <= 1'b0;
      acc      <= '0;
    end else begin
      a_east   <= a_west;
      va_east  <= va_west;
      b_south  <= b_north;
      vb_south <= vb_north;
      if (clear) begin
        acc <= '0;
      end else if (va_west && vb_north) begin
        acc <= DATA_W'(gdo::gdo_add(64'(acc), gdo::gdo_mult(64'(a_west), 64'(b_north))));
      end
    end
  end

endmodule

// File: rtl/stream_systolic_array.sv
// Elastic ROWS x COLS output-stationary matmul tile: skews operands in, drains rows out.
module stream_systolic_array
  import systolic_pkg::*;
#(
  parameter int unsigned ROWS   = 3,
  parameter int unsigned COLS   = 3,
  parameter int unsigned DATA_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W*ROWS-1:0] in_a,
  input  logic [DATA_W*COLS-1:0] in_b,
  input  logic                   in_last,
  input  logic                   acc_keep,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W*COLS-1:0] out_data,
  output logic                   out_last,
  output logic                   busy
);

  localparam int unsigned CntW = flush_cnt_w(ROWS, COLS);
  localparam int unsigned RowW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CntW-1:0] FlushLen = CntW'(ROWS + COLS - 1);
  localparam logic [RowW-1:0] LastRow = RowW'(ROWS - 1);

  state_e                   state_q;
  logic [CntW-1:0]          flush_cnt_q;
  logic [RowW-1:0]          row_q;
  logic [RowW-1:0]          sel_row;
  logic                     out_valid_q;
  logic                     out_last_q;
  logic [DATA_W*COLS-1:0]   out_data_q;
  logic [DATA_W*COLS-1:0]   row_data;
  logic                     in_fire;
  logic                     clear;

  logic [DATA_W-1:0] a_skew   [ROWS];
  logic              a_skew_v [ROWS];
  logic [DATA_W-1:0] b_skew   [COLS];
  logic              b_skew_v [COLS];
  logic [DATA_W-1:0] a_h      [ROWS][COLS];
  logic              va_h     [ROWS][COLS];
  logic [DATA_W-1:0] b_v      [ROWS][COLS];
  logic              vb_v     [ROWS][COLS];
  logic [DATA_W-1:0] acc_grid [ROWS][COLS];

  assign in_ready  = (state_q == StIdle) || (state_q == StAccum);
  assign in_fire   = in_valid && in_ready;
  // A fresh tile zeroes the sums on the edge its first beat enters the skew lines.
  assign clear     = in_fire && (state_q == StIdle) && !acc_keep;
  assign busy      = (state_q != StIdle);
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;

  for (genvar i = 0; i < ROWS; i++) begin : g_skew_a
    logic [DATA_W-1:0] d_q [i+1];
    logic              v_q [i+1];
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int k = 0; k <= i; k++) begin
          d_q[k] <= '0;
          v_q[k] <= 1'b0;
        end
      end else begin
        d_q[0] <= in_a[lane_hi(i, ROWS, DATA_W) -: DATA_W];
        v_q[0] <= in_fire;
        for (int k = 1; k <= i; k++) begin
          d_q[k] <= d_q[k-1];
          v_q[k] <= v_q[k-1];
        end
      end
    end
    assign a_skew[i]   = d_q[i];
    assign a_skew_v[i] = v_q[i];
  end

  for (genvar j = 0; j < COLS; j++) begin : g_skew_b
    logic [DATA_W-1:0] d_q [j+1];
    logic              v_q [j+1];
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int k = 0; k <= j; k++) begin
          d_q[k] <= '0;
          v_q[k] <= 1'b0;
        end
      end else begin
        d_q[0] <= in_b[lane_hi(j, COLS, DATA_W) -: DATA_W];
        v_q[0] <= in_fire;
        for (int k = 1; k <= j; k++) begin
          d_q[k] <= d_q[k-1];
          v_q[k] <= v_q[k-1];
        end
      end
    end
    assign b_skew[j]   = d_q[j];
    assign b_skew_v[j] = v_q[j];
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_col
      logic [DATA_W-1:0] a_w;
      logic              va_w;
      logic [DATA_W-1:0] b_n;
      logic              vb_n;
      if (j == 0) begin : g_west
        assign a_w  = a_skew[i];
        assign va_w = a_skew_v[i];
      end else begin : g_link_a
        assign a_w  = a_h[i][j-1];
        assign va_w = va_h[i][j-1];
      end
      if (i == 0) begin : g_north
        assign b_n  = b_skew[j];
        assign vb_n = b_skew_v[j];
      end else begin : g_link_b
        assign b_n  = b_v[i-1][j];
        assign vb_n = vb_v[i-1][j];
      end
      systolic_pe #(
        .DATA_W(DATA_W)
      ) u_pe (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .a_west   (a_w),
        .va_west  (va_w),
        .b_north  (b_n),
        .vb_north (vb_n),
        .a_east   (a_h[i][j]),
        .va_east  (va_h[i][j]),
        .b_south  (b_v[i][j]),
        .vb_south (vb_v[i][j]),
        .acc      (acc_grid[i][j])
      );
    end
  end

  // First DRAIN cycle loads row 0; every later load fetches the row after the one on display.
  always_comb begin
    sel_row  = (out_valid_q && (row_q != LastRow)) ? row_q + RowW'(1) : row_q;
    row_data = '0;
    for (int j = 0; j < COLS; j++) begin
      row_data[lane_hi(j, COLS, DATA_W) -: DATA_W] = acc_grid[sel_row][j];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      flush_cnt_q <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_fire) begin
            state_q <= in_last ? StFlush : StAccum;
            if (in_last) flush_cnt_q <= FlushLen;
          end
        end
        StAccum: begin
          if (in_fire && in_last) begin
            state_q     <= StFlush;
            flush_cnt_q <= FlushLen;
          end
        end
        StFlush: begin
          if (flush_cnt_q == CntW'(1)) begin
            state_q     <= StDrain;
            flush_cnt_q <= '0;
            row_q       <= '0;
          end else begin
            flush_cnt_q <= flush_cnt_q - CntW'(1);
          end
        end
        StDrain: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            out_data_q  <= row_data;
            out_last_q  <= (row_q == LastRow);
          end else if (out_ready) begin
            if (out_last_q) begin
              state_q     <= StIdle;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              row_q       <= '0;
            end else begin
              row_q      <= row_q + RowW'(1);
              out_data_q <= row_data;
              out_last_q <= ((row_q + RowW'(1)) == LastRow);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_systolic_array.sv
// Randomised bench for stream_systolic_array against a plain matrix-product model.
module tb_stream_systolic_array;

  localparam int R = 3;
  localparam int C = 3;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [W*R-1:0] in_a;
  logic [W*C-1:0] in_b;
  logic           in_last;
  logic           acc_keep;
  logic           out_valid;
  logic           out_ready;
  logic [W*C-1:0] out_data;
  logic           out_last;
  logic           busy;

  always #5 clk = ~clk;

  stream_systolic_array #(
    .ROWS   (R),
    .COLS   (C),
    .DATA_W (W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .acc_keep  (acc_keep),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int first_hs, last_hs, first_valid;

  logic [W-1:0] ta   [16][R];
  logic [W-1:0] tbv  [16][C];
  int unsigned  model_c [R][C];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic model_zero();
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++) model_c[i][j] = 0;
  endtask

  function automatic logic [W*C-1:0] model_row(input int r);
    logic [W*C-1:0] v;
    v = '0;
    for (int j = 0; j < C; j++) v[W*(C-j)-1 -: W] = 16'(model_c[r][j]);
    return v;
  endfunction

  // Stream k beats (column b of A, row b of B); gap < 0 picks random bubbles.
  task automatic send_tile(input int k, input bit keep, input int gap);
    int g;
    if (!keep) model_zero();
    for (int b = 0; b < k; b++) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      if (b > 0) begin
        repeat (g) begin
          in_valid = 1'b0;
          acc_keep = 1'($urandom_range(0, 1));
          tick();
        end
      end
      in_valid = 1'b1;
      in_last  = (b == k - 1);
      acc_keep = (b == 0) ? keep : 1'($urandom_range(0, 1));
      for (int i = 0; i < R; i++) in_a[W*(R-i)-1 -: W] = ta[b][i];
      for (int j = 0; j < C; j++) in_b[W*(C-j)-1 -: W] = tbv[b][j];
      check("in_ready_accept", {63'd0, in_ready}, 64'd1);
      tick();
      if (b == 0) first_hs = cyc;
      last_hs = cyc;
      for (int i = 0; i < R; i++)
        for (int j = 0; j < C; j++)
          model_c[i][j] = (model_c[i][j] + ta[b][i] * tbv[b][j]) & 32'hFFFF;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // mode 0: always ready, 1: random ready, 2: ready low for the first 5 valid cycles.
  task automatic collect(input int mode);
    int idx = 0;
    int n = 0;
    int low = 0;
    bit seen = 1'b0;
    bit hold = 1'b0;
    logic [W*C-1:0] hd;
    logic hl;
    while (idx < R && n < 400) begin
      // Junk beats while busy must be ignored.
      in_valid = 1'($urandom_range(0, 1));
      in_last  = 1'($urandom_range(0, 1));
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: begin
          if (out_valid && low < 5) begin
            out_ready = 1'b0;
            low++;
          end else begin
            out_ready = 1'b1;
          end
        end
      endcase
      check("in_ready_busy", {63'd0, in_ready}, 64'd0);
      if (hold) begin
        check("hold_data", out_data, hd);
        check("hold_last", {63'd0, out_last}, {63'd0, hl});
        check("hold_valid", {63'd0, out_valid}, 64'd1);
      end
      hold = 1'b0;
      if (out_valid) begin
        if (!seen) begin
          seen = 1'b1;
          first_valid = cyc;
        end
        if (out_ready) begin
          check("row_data", out_data, model_row(idx));
          check("row_last", {63'd0, out_last}, {63'd0, idx == R - 1});
          idx++;
        end else begin
          hold = 1'b1;
          hd   = out_data;
          hl   = out_last;
        end
      end
      tick();
      n++;
    end
    if (idx < R) check("drain_timeout", idx, R);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    check("busy_after", {63'd0, busy}, 64'd0);
    check("in_ready_after", {63'd0, in_ready}, 64'd1);
    check("out_valid_after", {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    bit keep;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    acc_keep  = 1'b0;
    out_ready = 1'b0;
    in_a      = '0;
    in_b      = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_out_last", {63'd0, out_last}, 64'd0);
    check("reset_out_data", out_data, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);

    // A = [[1,2,3],[4,5,6],[7,8,9]] against identity B.
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < R; i++) ta[b][i] = 16'(3 * i + b + 1);
      for (int j = 0; j < C; j++) tbv[b][j] = (j == b) ? 16'd1 : 16'd0;
    end
    send_tile(3, 1'b0, 0);
    check("busy_in_flush", {63'd0, busy}, 64'd1);
    collect(0);
    check("latency_first_valid", first_valid - first_hs, 3 + R + C - 1);

    send_tile(3, 1'b0, 2);
    collect(0);
    check("latency_after_last", first_valid - last_hs, R + C);

    // K = 1, then accumulate the same tile again.
    for (int i = 0; i < R; i++) ta[0][i] = 16'd2;
    for (int j = 0; j < C; j++) tbv[0][j] = 16'd3;
    send_tile(1, 1'b0, 0);
    collect(0);
    check("latency_k1", first_valid - first_hs, 1 + R + C - 1);
    check("k1_product", model_c[1][1], 6);
    send_tile(1, 1'b1, 0);
    collect(0);
    check("k1_keep_sum", model_c[2][0], 12);

    // Backpressure on the identity tile.
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < R; i++) ta[b][i] = 16'(3 * i + b + 1);
      for (int j = 0; j < C; j++) tbv[b][j] = (j == b) ? 16'd1 : 16'd0;
    end
    send_tile(3, 1'b0, 0);
    collect(2);

    // Reset during FLUSH discards partial sums.
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < R; i++) ta[b][i] = 16'($urandom);
      for (int j = 0; j < C; j++) tbv[b][j] = 16'($urandom);
    end
    send_tile(2, 1'b0, 0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("flush_reset_in_ready", {63'd0, in_ready}, 64'd1);
    check("flush_reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("flush_reset_busy", {63'd0, busy}, 64'd0);
    reset = 1'b0;
    model_zero();
    for (int i = 0; i < R; i++) ta[0][i] = 16'($urandom);
    for (int j = 0; j < C; j++) tbv[0][j] = 16'($urandom);
    send_tile(1, 1'b1, 0);
    collect(0);

    // Random tiles: random K, keep, bubbles and backpressure.
    for (int t = 0; t < 8; t++) begin
      k    = (t == 0) ? 7 : int'($urandom_range(1, 9));
      keep = (t == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      for (int b = 0; b < k; b++) begin
        for (int i = 0; i < R; i++) ta[b][i] = 16'($urandom);
        for (int j = 0; j < C; j++) tbv[b][j] = 16'($urandom);
      end
      send_tile(k, keep, -1);
      collect(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
